// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if: decoded scan-code bus from the PS/2 receiver to the glyph and control logic
interface ps2_scancode_rx_if;
  logic [7:0] o_key;
  logic       o_code_valid;
  logic [7:0] o_code;
  logic       o_code_break;
  logic       o_code_ext;
  logic       o_frame_err;
  modport master (output o_key, o_code_valid, o_code, o_code_break, o_code_ext, o_frame_err);
  modport slave  (input  o_key, o_code_valid, o_code, o_code_break, o_code_ext, o_frame_err);
endinterface

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 set-2 frame receiver with E0/F0 prefix decode; define PS2_BREAK_CLEAR_EN to blank o_key on release
module ps2_scancode_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ps2_clk,
  input  logic               i_ps2_data,
  ps2_scancode_rx_if.master  bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_PROCESS} state_t;
  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic [FW-1:0]          r_filt_cnt;
  logic                   r_filt, r_filt_d;
  logic [2:0]             r_cnt;
  logic [7:0]             r_data, r_key, w_key_nxt;
  logic                   r_par, r_ext, r_brk, r_err;
  logic [TW-1:0]          r_to;
  logic                   w_clk_s, w_dat_s, w_fall, w_active, w_timeout, w_frame_ok, w_is_code, w_err;
  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s    = r_dat_sync[SYNC_STAGES-1];
  assign w_fall     = r_filt_d & ~r_filt;
  assign w_active   = (r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_timeout  = w_active && !w_fall && (r_to == TW'(TIMEOUT_CYC));
  assign w_frame_ok = w_dat_s & (^{r_data, r_par});
  // Synchronize the pins and debounce the PS/2 clock; pins idle high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_filt_d   <= r_filt;
      if (w_clk_s == r_filt) r_filt_cnt <= '0;
      else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= w_clk_s;
        r_filt_cnt <= '0;
      end else r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end
  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end
  // Next-state logic; a mid-frame timeout always returns to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = (w_fall && !w_dat_s) ? S_DATA : S_IDLE;
      S_DATA:    w_next = (w_fall && r_cnt == 3'd7) ? S_PARITY : S_DATA;
      S_PARITY:  w_next = w_fall ? S_STOP : S_PARITY;
      S_STOP:    w_next = !w_fall ? S_STOP : w_frame_ok ? S_PROCESS : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
  end
  // Output decode: code events, error detection and next displayed key
  always_comb begin
    w_is_code = (r_state == S_PROCESS) && (r_data != 8'hE0) && (r_data != 8'hF0);
    w_err     = (r_state == S_STOP && w_fall && !w_frame_ok) || w_timeout;
`ifdef PS2_BREAK_CLEAR_EN
    w_key_nxt = !w_is_code ? r_key : !r_brk ? r_data : (r_data == r_key) ? 8'h00 : r_key;
`else
    w_key_nxt = (w_is_code && !r_brk) ? r_data : r_key;
`endif
  end
  // Frame datapath: bit capture, timeout counter, prefix flags and held key
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_data <= '0;
      r_par  <= 1'b0;
      r_to   <= '0;
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_key  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_cnt <= (r_state != S_DATA) ? 3'd0 : w_fall ? r_cnt + 3'd1 : r_cnt;
      if (r_state == S_DATA && w_fall) r_data[r_cnt] <= w_dat_s;
      if (r_state == S_PARITY && w_fall) r_par <= w_dat_s;
      r_to  <= (w_fall || r_state == S_IDLE) ? '0 : (r_to == TW'(TIMEOUT_CYC)) ? r_to : r_to + 1'b1;
      r_err <= w_err;
      r_key <= w_key_nxt;
      if (w_err || w_is_code) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_state == S_PROCESS) begin
        if (r_data == 8'hE0) r_ext <= 1'b1;
        if (r_data == 8'hF0) r_brk <= 1'b1;
      end
    end
  end
  assign bus.o_key        = w_key_nxt;
  assign bus.o_code_valid = w_is_code;
  assign bus.o_code       = r_data;
  assign bus.o_code_break = w_is_code & r_brk;
  assign bus.o_code_ext   = w_is_code & r_ext;
  assign bus.o_frame_err  = r_err;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: scoreboard bench driving PS/2 frames and checking decoded events
module tb_ps2_scancode_rx;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_ps2_clk = 1'b1, i_ps2_data = 1'b1;
  int   n_chk = 0, n_err = 0;
  typedef struct {bit err; logic [7:0] code; bit brk; bit ext; logic [7:0] key;} ev_t;
  ev_t        q[$];
  ev_t        m_ev;
  bit         m_brk = 0, m_ext = 0;
  logic [7:0] m_key = 8'h00;
  ps2_scancode_rx_if bus();
  ps2_scancode_rx dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_ps2_clk(i_ps2_clk), .i_ps2_data(i_ps2_data), .bus(bus));
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic push_err();
    q.push_back('{1'b1, 8'h00, 1'b0, 1'b0, m_key});
    m_brk = 0;
    m_ext = 0;
  endtask
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_brk) m_key = b;
`ifdef PS2_BREAK_CLEAR_EN
      else if (b == m_key) m_key = 8'h00;
`endif
      q.push_back('{1'b0, b, m_brk, m_ext, m_key});
      m_brk = 0;
      m_ext = 0;
    end
  endtask
  task automatic ps2_bit(input logic d);
    i_ps2_data = d;
    repeat (10) @(posedge i_clk);
    i_ps2_clk = 1'b0;
    repeat (20) @(posedge i_clk);
    i_ps2_clk = 1'b1;
    repeat (10) @(posedge i_clk);
  endtask
  task automatic drive(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    i_ps2_data = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input bit bad_par);
    if (bad_par) push_err();
    else model_byte(b);
    drive(b, bad_par, 11);
    repeat (20) @(posedge i_clk);
  endtask
  task automatic settle(input string tag);
    repeat (20) @(posedge i_clk);
    chk(tag, q.size(), 0);
    q.delete();
  endtask
  always @(negedge i_clk) begin
    if (i_rst_n && (bus.o_code_valid || bus.o_frame_err)) begin
      if (q.size() == 0) chk("spurious_event", {bus.o_code_valid, bus.o_frame_err}, 0);
      else begin
        m_ev = q.pop_front();
        chk("event_kind", {bus.o_code_valid, bus.o_frame_err}, m_ev.err ? 2'b01 : 2'b10);
        if (!m_ev.err) begin
          chk("code", bus.o_code, m_ev.code);
          chk("code_break", bus.o_code_break, m_ev.brk);
          chk("code_ext", bus.o_code_ext, m_ev.ext);
        end
        chk("key", bus.o_key, m_ev.key);
      end
    end
  end
  initial begin
    repeat (5) @(posedge i_clk);
    #1;
    chk("rst_key", bus.o_key, 0);
    chk("rst_valid", bus.o_code_valid, 0);
    chk("rst_code", bus.o_code, 0);
    chk("rst_flags", {bus.o_code_break, bus.o_code_ext}, 0);
    chk("rst_err", bus.o_frame_err, 0);
    i_rst_n = 1'b1;
    repeat (5) @(posedge i_clk);
    send(8'h16, 0);
    settle("pending_make");
    send(8'hF0, 0);
    send(8'h16, 0);
    settle("pending_break");
    chk("key_after_break", bus.o_key, m_key);
    send(8'hE0, 0);
    send(8'h75, 0);
    send(8'h1C, 0);
    settle("pending_ext");
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h7C, 0);
    settle("pending_ext_break");
    send(8'h1C, 1);
    settle("pending_parity");
    chk("key_after_parity", bus.o_key, m_key);
    send(8'hF0, 0);
    send(8'h1C, 1);
    send(8'h1C, 0);
    settle("pending_flag_clear");
    push_err();
    drive(8'h45, 0, 5);
    repeat (6000) @(posedge i_clk);
    chk("pending_timeout", q.size(), 0);
    send(8'h45, 0);
    settle("pending_after_timeout");
    i_ps2_data = 1'b0;
    @(posedge i_clk);
    i_ps2_clk = 1'b0;
    repeat (2) @(posedge i_clk);
    i_ps2_clk = 1'b1;
    repeat (3) @(posedge i_clk);
    i_ps2_data = 1'b1;
    repeat (20) @(posedge i_clk);
    #1;
    chk("glitch_key", bus.o_key, m_key);
    send(8'h29, 0);
    settle("pending_glitch");
    drive(8'h33, 0, 5);
    @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    #2;
    chk("midrst_key", bus.o_key, 0);
    chk("midrst_outs", {bus.o_code_valid, bus.o_code, bus.o_code_break, bus.o_code_ext, bus.o_frame_err}, 0);
    m_key = 8'h00;
    m_brk = 0;
    m_ext = 0;
    repeat (3) @(posedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(posedge i_clk);
    send(8'h5A, 0);
    settle("pending_after_reset");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- Receives PS/2 device-to-host frames from the keyboard pins and decodes set-2 make, break (F0) and extended (E0) prefixes.
- Presents a held key code for the glyph renderer, plus a one-cycle decoded-code event for control logic.
- Sits between the PS/2 pads and the key-to-pixel lookup; o_key feeds the lookup's key input directly.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers for i_ps2_clk and i_ps2_data (minimum 2).
- FILTER_LEN, 4, number of consecutive identical synchronized samples needed before the filtered PS/2 clock changes.
- TIMEOUT_CYC, 5000, i_clk cycles without a filtered falling edge, while mid-frame, before the frame is aborted.

Ports:
- i_clk, input, 1, system clock.
- i_rst_n, input, 1, reset, asynchronous, active-low.
- i_ps2_clk, input, 1, raw PS/2 clock pin, asynchronous to i_clk.
- i_ps2_data, input, 1, raw PS/2 data pin, asynchronous to i_clk.
- o_key, output, 8, last accepted make code, held between events.
- o_code_valid, output, 1, one-cycle pulse: a complete code (with any prefixes) has been decoded.
- o_code, output, 8, decoded code byte; valid while o_code_valid is high.
- o_code_break, output, 1, qualifies o_code_valid: the code was preceded by F0.
- o_code_ext, output, 1, qualifies o_code_valid: the code was preceded by E0.
- o_frame_err, output, 1, one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, prefix flags cleared, filtered clock = 1, timeout counter = 0.
- Input path: both pins pass through SYNC_STAGES flops.
  - Filtered clock takes the synchronized value only after FILTER_LEN consecutive equal samples.
  - A sample event is a 1→0 transition of the filtered clock; synchronized data is sampled in that same cycle.
- Frame format: 11 bits; start 0, 8 data bits LSB first, odd parity, stop 1.
- FSM states and transitions:
  - IDLE: sample 0 → DATA with bit count 0. Sample 1 → stay in IDLE (noise ignored).
  - DATA: shift each sample into bit[count]; after the 8th sample → PARITY.
  - PARITY: store the sample → STOP.
  - STOP: valid when stop==1 and XOR(data, parity)==1. Valid → PROCESS for one cycle; invalid → o_frame_err pulse, clear both prefix flags, → IDLE.
  - PROCESS:
    - byte E0 → set ext flag.
    - byte F0 → set break flag.
    - any other byte → o_code_valid=1, o_code=byte, o_code_break/o_code_ext = flags. Then clear the flags. If the break flag was 0, o_key ← byte in the same cycle.
    - always → IDLE.
- Latency: a stop-bit sample event in cycle N gives o_code_valid (or o_frame_err) at cycle N+1. The pulse width is exactly 1 cycle.
- Timeout counter:
  - Cleared on every sample event and in IDLE; otherwise increments.
  - Reaching TIMEOUT_CYC in DATA/PARITY/STOP → o_frame_err pulse, prefix flags cleared, → IDLE. The counter saturates and never wraps.
- Prefix bytes never pulse o_code_valid. E0 and F0 may arrive in either order; both flags persist until a non-prefix byte arrives or an error occurs.
- Async reset asserted mid-frame: immediate return to the reset state. The partial frame is discarded without an error pulse.
- o_key changes only in PROCESS and is otherwise held indefinitely.

Optional Feature:
- Macro: PS2_BREAK_CLEAR_EN.
- Defined: a break event whose o_code equals o_key sets o_key to 8'h00 in the same cycle as o_code_valid, so the displayed glyph blanks when the key is released. A break for any other code leaves o_key unchanged.
- Undefined: break events never modify o_key; the last make code stays displayed.

Test Plan:
- Frame 0x16 (data 0,1,1,0,1,0,0,0, parity 0, stop 1) → single o_code_valid with o_code=0x16, break=0, ext=0; o_key=0x16 one cycle after the stop-bit edge.
- Frames F0,16 after 0x16 → exactly one o_code_valid with code 0x16, break=1. o_key stays 0x16 without PS2_BREAK_CLEAR_EN and becomes 0x00 with it.
- Frames E0,75 → one pulse with o_code=0x75, ext=1, break=0; o_key=0x75. A following plain 0x1C → ext=0, confirming the flag was cleared.
- Frame 0x1C sent with parity bit 1 → o_frame_err pulse, no o_code_valid, o_key unchanged. The next valid 0x1C is accepted normally.
- Start plus 4 data bits, then clock idle for 6000 cycles (TIMEOUT_CYC=5000) → o_frame_err pulse around cycle 5000. A subsequent full 0x45 frame → o_code=0x45.
- 2-cycle low glitch on i_ps2_clk in IDLE (FILTER_LEN=4) → no state change and no outputs. i_rst_n low mid-frame → all outputs 0; the next frame decodes correctly.
